// File: rtl/vu_pkg.sv
// Shared types and default constants for the VU meter level processor.
package vu_pkg;

  typedef enum logic {
    PK_HOLD = 1'b0,
    PK_FALL = 1'b1
  } pk_state_e;

  localparam int unsigned DEF_DECAY_DIV     = 18432;
  localparam int unsigned DEF_HOLD_TICKS    = 50;
  localparam int unsigned DEF_DECAY_STEP    = 4;
  localparam int unsigned DEF_PEAK_STEP     = 2;
  localparam int unsigned DEF_TIMEOUT_TICKS = 100;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles (count 0..DIV-1).
module tick_prescaler #(
  parameter int unsigned DIV = vu_pkg::DEF_DECAY_DIV
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (enable) cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vu_level_proc.sv
// VU meter level processor: attack/decay bar level, peak-hold marker, sample timeout
// and saturating framing-error count.
//   state   | meaning
//   PK_HOLD | peak frozen, hold counter runs down on each decay tick
//   PK_FALL | peak falls by PEAK_STEP per tick, never below level
module vu_level_proc
  import vu_pkg::*;
#(
  parameter int unsigned DECAY_DIV     = DEF_DECAY_DIV,
  parameter int unsigned HOLD_TICKS    = DEF_HOLD_TICKS,
  parameter int unsigned DECAY_STEP    = DEF_DECAY_STEP,
  parameter int unsigned PEAK_STEP     = DEF_PEAK_STEP,
  parameter int unsigned TIMEOUT_TICKS = DEF_TIMEOUT_TICKS
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       error,
  output logic [7:0] level,
  output logic [7:0] peak,
  output logic       changed,
  output logic [7:0] error_count
);

  localparam int unsigned HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int unsigned TW = (TIMEOUT_TICKS > 0) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [7:0]    DSTEP     = 8'(DECAY_STEP);
  localparam logic [7:0]    PSTEP     = 8'(PEAK_STEP);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT_TICKS);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_TICKS - 1);

  logic          tick, accept, reject;
  logic [7:0]    level_q, level_d, target_q, target_d, err_q, err_d;
  logic [7:0]    peak_q, peak_fall, level_prev_q, peak_prev_q;
  logic [TW-1:0] tout_q, tout_d;
  logic [HW-1:0] hold_q;
  logic          changed_q;
  pk_state_e     state_q;

  tick_prescaler #(.DIV(DECAY_DIV)) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  // target_d already reflects this cycle's sample or timeout, so decay chases the new target
  always_comb begin
    accept   = enable && load && !error;
    reject   = enable && load && error;
    target_d = target_q;
    tout_d   = tout_q;
    if (accept) begin
      target_d = data_in;
      tout_d   = '0;
    end else if (tick && tout_q != TO_MAX) begin
      tout_d = tout_q + TW'(1);
      if (tout_q == TO_LAST) target_d = '0;
    end

    level_d = level_q;
    if (accept && data_in >= level_q)
      level_d = data_in;
    else if (tick && level_q > target_d)
      level_d = ((level_q - target_d) > DSTEP) ? level_q - DSTEP : target_d;

    peak_fall = (peak_q > level_d && (peak_q - level_d) > PSTEP) ? peak_q - PSTEP : level_d;
    err_d     = (reject && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= PK_HOLD;
      peak_q  <= '0;
      hold_q  <= '0;
    end else if (accept && data_in > peak_q) begin
      state_q <= PK_HOLD;
      peak_q  <= data_in;
      hold_q  <= HOLD_LOAD;
    end else if (tick) begin
      case (state_q)
        PK_HOLD: begin
          if (hold_q <= HW'(1)) begin
            hold_q  <= '0;
            state_q <= PK_FALL;
          end else begin
            hold_q <= hold_q - HW'(1);
          end
        end
        PK_FALL: peak_q <= peak_fall;
        default: state_q <= PK_HOLD;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      level_q      <= '0;
      target_q     <= '0;
      tout_q       <= '0;
      err_q        <= '0;
      level_prev_q <= '0;
      peak_prev_q  <= '0;
      changed_q    <= 1'b0;
    end else begin
      level_q      <= level_d;
      target_q     <= target_d;
      tout_q       <= tout_d;
      err_q        <= err_d;
      level_prev_q <= level_q;
      peak_prev_q  <= peak_q;
      changed_q    <= enable && (level_q != level_prev_q || peak_q != peak_prev_q);
    end
  end

  assign level       = level_q;
  assign peak        = peak_q;
  assign changed     = changed_q;
  assign error_count = err_q;

endmodule

// File: tb/tb_vu_level_proc.sv
// Randomized + directed scoreboard bench for vu_level_proc against a behavioural model.
module tb_vu_level_proc;

  localparam int DIV = 4, HOLD = 3, DSTEP = 4, PSTEP = 2, TO = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, load = 1'b0, error = 1'b0;
  logic [7:0] data_in = '0;
  logic [7:0] level, peak, error_count;
  logic       changed;

  int total = 0, bad = 0;

  typedef struct {
    int lvl; int pk; int chg; int err;
  } exp_t;
  exp_t sb[$];

  // Behavioural model state
  int m_lvl, m_pk, m_tgt, m_err, m_en_cycles, m_idle_ticks, m_since, m_prev_l, m_prev_p, m_chg;

  vu_level_proc #(
    .DECAY_DIV(DIV), .HOLD_TICKS(HOLD), .DECAY_STEP(DSTEP),
    .PEAK_STEP(PSTEP), .TIMEOUT_TICKS(TO)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .data_in(data_in),
    .load(load), .error(error), .level(level), .peak(peak),
    .changed(changed), .error_count(error_count)
  );

  always #5 clock = ~clock;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_step(input bit r, input bit e, input int d, input bit l, input bit er);
    bit tick, acc;
    if (r) begin
      m_lvl = 0; m_pk = 0; m_tgt = 0; m_err = 0; m_en_cycles = 0; m_idle_ticks = 0;
      m_since = HOLD; m_prev_l = 0; m_prev_p = 0; m_chg = 0;
      return;
    end
    m_chg    = (e && (m_lvl != m_prev_l || m_pk != m_prev_p)) ? 1 : 0;
    m_prev_l = m_lvl;
    m_prev_p = m_pk;
    if (!e) return;
    tick = ((m_en_cycles % DIV) == DIV - 1);
    m_en_cycles++;
    acc = l && !er;
    if (l && er && m_err < 255) m_err++;
    if (acc) begin
      m_tgt = d; m_idle_ticks = 0;
    end else if (tick && m_idle_ticks < TO) begin
      m_idle_ticks++;
      if (m_idle_ticks == TO) m_tgt = 0;
    end
    if (acc && d >= m_lvl) m_lvl = d;
    else if (tick && m_lvl > m_tgt) m_lvl = imax(m_lvl - DSTEP, m_tgt);
    // peak holds for HOLD ticks after capture, then falls on every later tick
    if (acc && d > m_pk) begin
      m_pk = d; m_since = 0;
    end else if (tick) begin
      if (m_since < HOLD) m_since++;
      else m_pk = imax(m_pk - PSTEP, m_lvl);
    end
  endtask

  task automatic drive(input bit r, input bit e, input int d, input bit l, input bit er);
    exp_t x;
    @(negedge clock);
    reset = r; enable = e; data_in = 8'(d); load = l; error = er;
    model_step(r, e, d, l, er);
    x.lvl = m_lvl; x.pk = m_pk; x.chg = m_chg; x.err = m_err;
    sb.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 1, 0, 0, 0);
  endtask

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("level", int'(level), e.lvl);
        check("peak", int'(peak), e.pk);
        check("changed", int'(changed), e.chg);
        check("error_count", int'(error_count), e.err);
        total++;
        if (peak < level) begin
          bad++;
          $display("FAIL peak_ge_level got peak=%0d level=%0d", peak, level);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n;
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 55, 1, 0);
    // attack, then changed one edge later
    drive(0, 1, 200, 1, 0);
    idle(3);
    // decay towards 10 with refreshed target so the timeout never fires
    for (int i = 0; i < 260; i++) drive(0, 1, 10, (i % 12) == 0, 0);
    // error saturation
    for (int i = 0; i < 300; i++) drive(0, 1, $urandom_range(0, 255), 1, 1);
    idle(4);
    // load coinciding with a tick while level is 50
    drive(1, 1, 0, 0, 0);
    drive(0, 1, 50, 1, 0);
    n = 0;
    while ((m_en_cycles % DIV) != DIV - 1 && n < 10) begin drive(0, 1, 0, 0, 0); n++; end
    drive(0, 1, 100, 1, 0);
    idle(3);
    // timeout then full decay to zero
    drive(0, 1, 80, 1, 0);
    idle(200);
    // freeze mid-fall
    drive(0, 1, 200, 1, 0);
    drive(0, 1, 10, 1, 0);
    n = 0;
    while (!(m_since >= HOLD && m_pk > m_lvl + 8) && n < 100) begin drive(0, 1, 10, 0, 0); n++; end
    idle(5);
    for (int i = 0; i < 20; i++) drive(0, 0, $urandom_range(0, 255), $urandom_range(0, 1), $urandom_range(0, 1));
    idle(10);
    // reset mid-hold
    drive(0, 1, 150, 1, 0);
    idle(5);
    drive(1, 1, 250, 1, 0);
    idle(3);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), $urandom_range(0, 255),
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 4) == 0));
    end
    idle(2);
    @(negedge clock);
    @(negedge clock);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vu_level_proc.md
VU_LEVEL_PROC -- requirements
Module: vu_level_proc

Interface
REQ-001 Parameter DECAY_DIV, default 18432: clock cycles per decay tick (10 ms at the 1.8432 MHz UART clock).
REQ-002 Parameter HOLD_TICKS, default 50: decay ticks the peak marker holds before falling.
REQ-003 Parameter DECAY_STEP, default 4: level decrement per decay tick.
REQ-004 Parameter PEAK_STEP, default 2: peak decrement per decay tick while falling.
REQ-005 Parameter TIMEOUT_TICKS, default 100: decay ticks without an accepted sample before the target is forced to 0.
REQ-006 clock  input  1  single clock, shared with the UART receiver; all logic on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 enable  input  1  high = run; low = freeze all state and ignore load.
REQ-009 data_in  input  8  received sample from the UART receiver.
REQ-010 load  input  1  one-cycle strobe: data_in is valid.
REQ-011 error  input  1  framing error qualifier for the current load.
REQ-012 level  output  8  smoothed bar height to the VGA stage.
REQ-013 peak  output  8  peak-hold marker height to the VGA stage.
REQ-014 changed  output  1  one-cycle pulse when level or peak changed on the previous edge.
REQ-015 error_count  output  8  saturating count of rejected samples.

Function
REQ-016 A sample SHALL be accepted when enable && load && !error; target <= data_in.
REQ-017 enable && load && error SHALL discard the sample and increment error_count, saturating at 255.
REQ-018 A prescaler SHALL emit a one-cycle tick every DECAY_DIV enabled cycles, counting 0..DECAY_DIV-1 and then wrapping.
REQ-019 Attack: on an accepted sample >= level, level SHALL equal the sample on the next edge (latency 1 cycle).
REQ-020 Decay: on a tick with level > target, level SHALL become max(level - DECAY_STEP, target), with no underflow below 0.
REQ-021 Accepted sample and tick in the same cycle: attack SHALL take priority; if the sample < level, the decay SHALL use the new target in that cycle.
REQ-022 Peak FSM states: PK_HOLD and PK_FALL; reset state PK_HOLD.
REQ-023 In any state, an accepted sample > peak SHALL set peak to the sample, reload the hold counter with HOLD_TICKS, and enter PK_HOLD.
REQ-024 PK_HOLD SHALL decrement the hold counter on each tick; on reaching 0 it SHALL go to PK_FALL.
REQ-025 In PK_FALL, each tick SHALL set peak to max(peak - PEAK_STEP, level), computed after the level update of that cycle.
REQ-026 The invariant peak >= level SHALL hold on every cycle.
REQ-027 A timeout counter SHALL reset on every accepted sample and count ticks; at TIMEOUT_TICKS it SHALL set target to 0 and saturate there.
REQ-028 changed SHALL be registered and equal (level or peak differed from its prior value on the previous edge).
REQ-029 With enable low, no counter, FSM state or output SHALL change, and changed SHALL be 0.

Reset
REQ-030 Reset SHALL take priority over enable and load.
REQ-031 Reset values: level=0, peak=0, target=0, changed=0, error_count=0, FSM=PK_HOLD, hold counter=0, prescaler=0, timeout counter=0.
REQ-032 A reset asserted mid-hold or mid-fall SHALL return everything to the REQ-031 values on the next edge.

Structure
REQ-033 Package vu_pkg SHALL hold the peak FSM state encoding and the default parameter constants.
REQ-034 The prescaler SHALL be a sub-module, tick_prescaler, with parameter DIV and ports clock, reset, enable, tick.

Verification (DECAY_DIV=4, HOLD_TICKS=3, DECAY_STEP=4, PEAK_STEP=2, TIMEOUT_TICKS=5)
REQ-035 Reset, then load 200 -> one edge later level=200, peak=200, and changed=1 on the following edge.
REQ-036 Load 200, then 10 -> level falls 200,196,192,... one step per tick, stopping at exactly 10; peak stays at 200 for 3 ticks, then falls by 2 per tick and never drops below level.
REQ-037 Load with error=1 for 300 strobes -> level and peak unchanged; error_count saturates at 255.
REQ-038 Load 100 coinciding with a tick while level=50 -> level=100 next edge, with no decay applied.
REQ-039 Load 80, then idle -> after 5 ticks target=0; level decays to 0 and peak falls to 0.
REQ-040 enable low for 20 cycles mid-fall -> outputs frozen, changed=0; reset asserted mid-hold -> all REQ-031 values next edge.
